// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues single-outstanding reads to
// program memory and queues returned words in a small prefetch FIFO for the core.
module inst_fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 16,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [ADDR_W-1:0] pm_addr,
  output logic              pm_rd,
  input  logic [DATA_W-1:0] pm_data,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              done,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0]     PTR_ONE = PW'(1'b1);
  localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1'b1);
  localparam logic [CW:0]       DEPTH_V = (CW+1)'(DEPTH);

  logic [ADDR_W-1:0] pc_r;
  logic              inflight_r;
  logic [ADDR_W-1:0] inflight_pc_r;
  logic [CW-1:0]     count_r;
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [DATA_W-1:0] data_mem_r [DEPTH];
  logic [ADDR_W-1:0] pc_mem_r   [DEPTH];

  logic              pop_s;
  logic              push_s;
  logic              issue_s;
  logic [CW:0]       need_s;

  assign inst_valid = (count_r != {CW{1'b0}});
  assign inst       = data_mem_r[rd_ptr_r];
  assign inst_pc    = pc_mem_r[rd_ptr_r];
  assign pm_addr    = pc_r;
  assign pm_rd      = issue_s;

  // Issue decision: the in-flight read already owns a FIFO slot, so count it.
  always_comb begin
    pop_s   = done & inst_valid;
    push_s  = inflight_r;
    need_s  = {1'b0, count_r} + (CW+1)'(inflight_r) - (CW+1)'(pop_s);
    issue_s = 1'b0;
    if (enable && !redirect && !reset) begin
      issue_s = (need_s < DEPTH_V);
    end else begin
      issue_s = 1'b0;
    end
  end

  // Fetch PC, in-flight tag and FIFO state; redirect flushes and drops any return.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r          <= RESET_PC;
      inflight_r    <= 1'b0;
      inflight_pc_r <= '0;
      count_r       <= '0;
      wr_ptr_r      <= '0;
      rd_ptr_r      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_mem_r[i] <= '0;
        pc_mem_r[i]   <= '0;
      end
    end else if (redirect) begin
      pc_r       <= redirect_pc;
      inflight_r <= 1'b0;
      count_r    <= '0;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
    end else begin
      inflight_r <= issue_s;
      if (issue_s) begin
        inflight_pc_r <= pc_r;
        pc_r          <= pc_r + PC_ONE;
      end
      if (push_s) begin
        data_mem_r[wr_ptr_r] <= pm_data;
        pc_mem_r[wr_ptr_r]   <= inflight_pc_r;
        wr_ptr_r             <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_r + CW'(push_s) - CW'(pop_s);
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: directed stimulus pushes expected retirements,
// a negedge monitor pops and compares whenever the core retires an instruction.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [7:0]  pm_addr;
  logic        pm_rd;
  logic [15:0] pm_data;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        done;
  logic [15:0] inst;
  logic [7:0]  inst_pc;
  logic        inst_valid;

  logic [15:0] base;
  logic [23:0] sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  inst_fetch_unit #(.ADDR_W(8), .DATA_W(16), .DEPTH(2), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset), .enable(enable), .pm_addr(pm_addr), .pm_rd(pm_rd),
    .pm_data(pm_data), .redirect(redirect), .redirect_pc(redirect_pc), .done(done),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid)
  );

  always #5 clk = ~clk;

  // Program memory: word at address a is base + a, one-cycle read latency.
  always @(posedge clk) pm_data <= base + {8'h00, pm_addr};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      at_neg();
      next();
    end
    chk("sb_drained", sb.size(), 0);
  endtask

  // Monitor: compare each retired instruction with the scoreboard head.
  always @(negedge clk) begin
    if (!reset && !redirect && done && inst_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL retire: got inst %h pc %h, expected none", inst, inst_pc);
      end else begin
        chk("retire", {8'h00, inst, inst_pc}, {8'h00, sb.pop_front()});
      end
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b0; done = 1'b0; redirect = 1'b0;
    redirect_pc = 8'h00; base = 16'h1234;
    next(); next();
    at_neg();
    chk("rst_pm_rd", pm_rd, 1'b0);
    chk("rst_valid", inst_valid, 1'b0);
    chk("rst_inst", inst, 16'h0000);
    chk("rst_inst_pc", inst_pc, 8'h00);

    // First fetch and backpressure with done low
    next(); reset = 1'b0; enable = 1'b1;
    at_neg();
    chk("c0_pm_rd", pm_rd, 1'b1);
    chk("c0_pm_addr", pm_addr, 8'h00);
    next(); at_neg();
    chk("c1_pm_rd", pm_rd, 1'b1);
    chk("c1_pm_addr", pm_addr, 8'h01);
    chk("c1_valid", inst_valid, 1'b0);
    next(); at_neg();
    chk("c2_valid", inst_valid, 1'b1);
    chk("c2_inst", inst, 16'h1234);
    chk("c2_inst_pc", inst_pc, 8'h00);
    chk("c2_pm_rd", pm_rd, 1'b0);
    for (int i = 0; i < 3; i++) begin
      next(); at_neg();
      chk("bp_stall", pm_rd, 1'b0);
    end
    next(); sb.push_back({16'h1234, 8'h00}); done = 1'b1;
    at_neg();
    chk("pop_pm_rd", pm_rd, 1'b1);
    chk("pop_pm_addr", pm_addr, 8'h02);
    next(); done = 1'b0;
    at_neg();
    chk("pop_head_inst", inst, 16'h1235);
    chk("pop_head_pc", inst_pc, 8'h01);

    // Streaming from 0x00 with done held high
    next(); redirect = 1'b1; redirect_pc = 8'h00; base = 16'hA000;
    at_neg();
    chk("redir_no_rd", pm_rd, 1'b0);
    next(); redirect = 1'b0; done = 1'b1; enable = 1'b1;
    for (int i = 0; i < 8; i++) sb.push_back({16'hA000 + 16'(i), 8'(i)});
    for (int i = 0; i < 8; i++) begin
      at_neg();
      if (i >= 2) chk("stream_valid", inst_valid, 1'b1);
      next();
    end
    enable = 1'b0;
    drain(3);

    // Redirect in the return cycle of 0x05 drops that word
    redirect = 1'b1; redirect_pc = 8'h05; done = 1'b0; enable = 1'b1;
    at_neg(); next();
    redirect = 1'b0;
    at_neg();
    chk("r5_pm_rd", pm_rd, 1'b1);
    chk("r5_pm_addr", pm_addr, 8'h05);
    next(); redirect = 1'b1; redirect_pc = 8'h40;
    at_neg();
    chk("r40_no_rd", pm_rd, 1'b0);
    next(); redirect = 1'b0; done = 1'b1;
    sb.push_back({16'hA040, 8'h40});
    sb.push_back({16'hA041, 8'h41});
    at_neg();
    chk("r40_flushed", inst_valid, 1'b0);
    chk("r40_pm_addr", pm_addr, 8'h40);
    next(); at_neg(); next();
    enable = 1'b0;
    drain(3);

    // PC wrap through 0xFF
    redirect = 1'b1; redirect_pc = 8'hFE; enable = 1'b1;
    at_neg(); next();
    redirect = 1'b0;
    sb.push_back({16'hA0FE, 8'hFE});
    sb.push_back({16'hA0FF, 8'hFF});
    sb.push_back({16'hA000, 8'h00});
    sb.push_back({16'hA001, 8'h01});
    for (int i = 0; i < 4; i++) begin
      at_neg(); next();
    end
    enable = 1'b0;
    drain(3);

    // Redirect together with done while two entries are queued
    redirect = 1'b1; redirect_pc = 8'h10; done = 1'b0; enable = 1'b1;
    at_neg(); next();
    redirect = 1'b0;
    at_neg(); next();
    at_neg(); next();
    enable = 1'b0;
    at_neg(); next();
    at_neg();
    chk("q2_valid", inst_valid, 1'b1);
    chk("q2_head_pc", inst_pc, 8'h10);
    next(); redirect = 1'b1; redirect_pc = 8'h20; done = 1'b1;
    at_neg(); next();
    redirect = 1'b0; done = 1'b0; enable = 1'b1;
    sb.push_back({16'hA020, 8'h20});
    at_neg();
    chk("rd_flushed", inst_valid, 1'b0);
    chk("rd_pm_rd", pm_rd, 1'b1);
    chk("rd_pm_addr", pm_addr, 8'h20);
    next(); enable = 1'b0; done = 1'b1;
    drain(3);

    // Reset mid-stream
    redirect = 1'b1; redirect_pc = 8'h30; enable = 1'b1;
    at_neg(); next();
    redirect = 1'b0;
    sb.push_back({16'hA030, 8'h30});
    sb.push_back({16'hA031, 8'h31});
    sb.push_back({16'hA032, 8'h32});
    for (int i = 0; i < 3; i++) begin
      at_neg(); next();
    end
    reset = 1'b1;
    sb.delete();
    at_neg();
    chk("mrst_no_rd", pm_rd, 1'b0);
    next(); at_neg();
    chk("mrst_valid", inst_valid, 1'b0);
    chk("mrst_pm_rd", pm_rd, 1'b0);
    next(); reset = 1'b0; done = 1'b0; enable = 1'b1;
    sb.push_back({16'hA000, 8'h00});
    at_neg();
    chk("mrst_pm_rd_after", pm_rd, 1'b1);
    chk("mrst_restart_pc", pm_addr, 8'h00);
    next(); enable = 1'b0; done = 1'b1;
    drain(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
